// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix-up in a final cycle.
module mult_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            hi_we,
  input  logic            lo_we,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                res_neg_q, res_neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic                div0_q, div0_d;
  logic                done_q, done_d;

  logic                is_signed;
  logic                a_neg, b_neg;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       rem_sh;
  logic [XLEN-1:0]     rem_sub;
  logic                div_ge;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quot, rem;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & rs_data[XLEN-1];
  assign b_neg     = is_signed & rt_data[XLEN-1];

  // Multiply: acc upper half accumulates, then the whole 65-bit result shifts right.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);

  // Divide: acc upper = partial remainder, acc lower = quotient; dividend bits come from a_q MSB.
  assign rem_sh  = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
  assign div_ge  = rem_sh >= {1'b0, b_q};
  assign rem_sub = rem_sh[XLEN-1:0] - b_q;

  assign prod = res_neg_q ? -acc_q : acc_q;
  assign quot = res_neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem  = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          a_d       = a_neg ? -rs_data : rs_data;
          b_d       = b_neg ? -rt_data : rt_data;
          res_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          div0_d    = (rt_data == '0);
          cnt_d     = '0;
          acc_d     = '0;
          state_d   = RUN;
        end else begin
          if (hi_we) hi_d = rs_data;
          if (lo_we) lo_d = rs_data;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q[1]) begin
          acc_d = {(div_ge ? rem_sub : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
          a_d   = a_q << 1;
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
          b_d   = b_q >> 1;
        end
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          // Divide by zero leaves |A| as remainder; the quotient is forced rather than sign-fixed.
          hi_d = rem;
          lo_d = div0_q ? '1 : quot;
        end else begin
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors, corner sequences and
// randomized operations against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: {hi, lo} from the architectural rules using 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'd0: begin p = sa * sb; return p; end
      2'd1: begin up = {32'd0, a} * {32'd0, b}; return up; end
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (done !== 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk({name, " done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int bcnt;
    bcnt = 0;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && done !== 1'b1; i++) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
    end
    chk({name, " done"}, 32'(done), 32'd1);
    chk({name, " busy_cycles"}, 32'(bcnt), 32'd33);
    chk({name, " busy_at_done"}, 32'(busy), 32'd0);
    chk({name, " hi"}, hi, ehi);
    chk({name, " lo"}, lo, elo);
    @(negedge clk);
    chk({name, " done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dcnt;
    logic [31:0] a, b, lo_save;
    logic [1:0]  o;
    logic [63:0] exp;

    vecs[0]  = '{"multu_max",   2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{"mult_m7x3",   2'd0, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{"div_m7d2",    2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{"divu_100d7",  2'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4]  = '{"div_ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5]  = '{"divu_5d0",    2'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[6]  = '{"div_m5d0",    2'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7]  = '{"mult_minsq",  2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[8]  = '{"div_7dm2",    2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9]  = '{"multu_3x4",   2'd1, 32'd3,         32'd4,         32'd0,         32'd12};
    vecs[10] = '{"divu_big",    2'd3, 32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF};

    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);

    // mthi before an op, then mthi/mtlo attempted while busy
    @(negedge clk); hi_we = 1'b1; rs_data = 32'h5555;
    @(negedge clk); hi_we = 1'b0;
    chk("mthi idle", hi, 32'h5555);
    lo_save = lo;
    start = 1'b1; op = 2'd1; rs_data = 32'd2; rt_data = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; rs_data = 32'h1234;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
    chk("busy hi_we hi", hi, 32'h5555);
    chk("busy lo_we lo", lo, lo_save);
    wait_done("busy_we");
    chk("busy_we result hi", hi, 32'd0);
    chk("busy_we result lo", lo, 32'd6);

    // mthi+mtlo together in idle
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; rs_data = 32'hABCD;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
    chk("mthilo hi", hi, 32'hABCD);
    chk("mthilo lo", lo, 32'hABCD);

    // start wins over hi_we in the same cycle
    start = 1'b1; hi_we = 1'b1; op = 2'd1; rs_data = 32'd5; rt_data = 32'd6;
    @(negedge clk); start = 1'b0; hi_we = 1'b0;
    chk("start_we busy", 32'(busy), 32'd1);
    chk("start_we hi kept", hi, 32'hABCD);
    wait_done("start_we");
    chk("start_we hi", hi, 32'd0);
    chk("start_we lo", lo, 32'd30);

    // start pulsed mid-operation is ignored
    @(negedge clk); start = 1'b1; op = 2'd3; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd1; rs_data = 32'd3; rt_data = 32'd4;
    @(negedge clk); start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) dcnt++;
      @(negedge clk);
    end
    chk("busy_start done_count", 32'(dcnt), 32'd1);
    chk("busy_start hi", hi, 32'd2);
    chk("busy_start lo", lo, 32'd14);

    // randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp = model(o, a, b);
      run_op($sformatf("rand%0d op%0d", n, o), o, a, b, exp[63:32], exp[31:0]);
    end

    // asynchronous reset mid-RUN aborts; lo currently nonzero
    @(negedge clk); start = 1'b1; op = 2'd3; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst busy", 32'(busy), 32'd0);
    chk("async_rst hi", hi, 32'd0);
    chk("async_rst lo", lo, 32'd0);
    @(negedge clk); reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (done === 1'b1) dcnt++;
      @(negedge clk);
    end
    chk("async_rst no_done", 32'(dcnt), 32'd0);
    chk("async_rst lo held", lo, 32'd0);
    run_op("post_rst multu", 2'd1, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core. Sits directly downstream of the register file: its operands are the register file's two read ports (rs, rt). Its HI/LO outputs feed back to the write-back mux for mfhi/mflo. The core stalls on `busy`.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  launch the operation in `op` with `rs_data`/`rt_data`; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data`  in  32  operand A (dividend / multiplicand) from register-file read port 1.
- `rt_data`  in  32  operand B (divisor / multiplier) from register-file read port 2.
- `hi_we`  in  1  mthi: HI <= `rs_data`.
- `lo_we`  in  1  mtlo: LO <= `rs_data`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO have been updated by an operation.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN when `start`=1.
  - RUN -> FIX after the 32nd iteration (5-bit counter at 31).
  - FIX -> IDLE unconditionally.
- On the `start` edge:
  - Latch `op`.
  - Latch operand magnitudes: absolute value for MULT/DIV, raw for MULTU/DIVU.
  - Record the result sign (A^B) and the remainder sign (A).
  - Clear the counter and the 64-bit accumulator.
- RUN, one iteration per cycle:
  - Multiply: shift-add, consuming one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle.
- FIX:
  - Apply sign correction: two's-complement negate the 64-bit product, quotient or remainder where required.
  - Write HI/LO. For multiply, HI = upper 32 bits and LO = lower 32 bits. For divide, HI = remainder and LO = quotient.
- Signed semantics:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero (`rt_data`=0):
  - Runs the full latency, no exception.
  - LO = 0xFFFFFFFF, HI = `rs_data`, for both DIV and DIVU.
- DIV overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0.
- mthi/mtlo:
  - Accepted only in IDLE with `start`=0; take effect at the next edge.
  - `hi_we` and `lo_we` together write both registers.
  - If `start` is asserted in the same cycle, `start` wins and the writes are dropped.
- `start`, `hi_we` and `lo_we` are ignored while `busy`=1. HI/LO hold their old values until FIX.
- Reset:
  - Values: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0.
  - Reset mid-operation aborts the operation: no `done`, HI/LO stay 0.

## Timing
- Edge E0 samples `start`=1.
- `busy`=1 in the cycles after edges E0 through E32 (33 cycles); `busy` is a registered state decode, so no combinational path from `start`.
- Edge E33 writes HI/LO. `done`=1 and `busy`=0 for the cycle after E33.
- A new `start` is accepted at E34 at the earliest; back-to-back throughput is one operation per 34 cycles.
- `hi`/`lo` are direct register outputs, with no bypass of in-flight results.
- mthi/mtlo write latency is 1 edge.

## Test plan
- Reset mid-RUN:
  - Start DIVU and assert `reset` at cycle 10 -> `hi`=`lo`=0 and `busy`=0 immediately (asynchronously), and no `done` ever.
  - Release reset and start MULTU 3*4 -> `lo`=12.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> after 33 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001, and `done` high for exactly 1 cycle.
- MULT -7 * 3 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- Signed and unsigned divide:
  - DIV -7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 100 / 7 -> `lo`=14, `hi`=2.
- Divide boundaries:
  - DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
  - DIVU 5 / 0 -> `lo`=0xFFFFFFFF, `hi`=5.
  - Both take 33 `busy` cycles.
- Writes and starts during and around busy:
  - Assert `hi_we` with `rs_data`=0x1234 while busy -> `hi` unchanged until FIX.
  - In IDLE, `hi_we`+`lo_we` with 0xABCD -> both 0xABCD next cycle.
  - `start` plus `hi_we` in the same cycle -> the operation starts and HI is not written.
  - `start` pulsed during `busy` -> ignored, and only one `done`.
